// File: rtl/demux_1x4_if.sv
// Bus bundle for the registered 1-to-4 demultiplexer: enable, data and select
// travel towards the demux, the four routed outputs travel back.
interface demux_1x4_if #(
    parameter int WIDTH = 1
);
    logic             en;
    logic [WIDTH-1:0] d;
    logic             s1;
    logic             s0;
    logic [WIDTH-1:0] y0;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] y2;
    logic [WIDTH-1:0] y3;

    modport master (
        output en, d, s1, s0,
        input  y0, y1, y2, y3
    );

    modport slave (
        input  en, d, s1, s0,
        output y0, y1, y2, y3
    );
endinterface

// File: rtl/demux_1x4.sv
// Registered 1-to-4 demultiplexer: d is routed to y[{s1,s0}] one clock later.
// Optional macro DEMUX_HOLD_UNSEL_EN keeps unselected outputs instead of clearing them.
module demux_1x4 #(
    parameter int WIDTH = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    demux_1x4_if.slave  bus
);

    logic [3:0][WIDTH-1:0] y_q;
    logic [3:0][WIDTH-1:0] y_d;
    logic [1:0]            sel;

    assign sel = {bus.s1, bus.s0};

    always_comb begin
        y_d = y_q;
        if (bus.en) begin
`ifdef DEMUX_HOLD_UNSEL_EN
            // Addressable-register mode: only the selected slot is written.
            y_d[sel] = bus.d;
`else
            y_d      = '0;
            y_d[sel] = bus.d;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign bus.y0 = y_q[0];
    assign bus.y1 = y_q[1];
    assign bus.y2 = y_q[2];
    assign bus.y3 = y_q[3];

endmodule

// File: tb/tb_demux_1x4.sv
// Bench for demux_1x4: a WIDTH=8 and a WIDTH=1 instance share clock, reset, enable and select.
module tb_demux_1x4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    demux_1x4_if #(.WIDTH(8)) bus8 ();
    demux_1x4_if #(.WIDTH(1)) bus1 ();

    demux_1x4 #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    demux_1x4 #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    typedef struct {
        logic        en;
        logic [1:0]  sel;
        logic [7:0]  d8;
        logic        d1;
        logic [31:0] exp8;
        logic [3:0]  exp1;
    } vec_t;

    typedef struct {
        logic [31:0] exp8;
        logic [3:0]  exp1;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[8];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic drive(input logic en, input logic [1:0] sel, input logic [7:0] d8, input logic d1);
        bus8.en = en;
        bus1.en = en;
        {bus8.s1, bus8.s0} = sel;
        {bus1.s1, bus1.s0} = sel;
        bus8.d = d8;
        bus1.d = d1;
    endtask

    task automatic push_exp(input logic [31:0] e8, input logic [3:0] e1);
        exp_t e;
        e.exp8 = e8;
        e.exp1 = e1;
        sb.push_back(e);
    endtask

    task automatic check_pop(input string name);
        exp_t        e;
        logic [31:0] act8;
        logic [3:0]  act1;
        if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL %s: scoreboard empty, no expected value available", name);
            return;
        end
        e    = sb.pop_front();
        act8 = {bus8.y3, bus8.y2, bus8.y1, bus8.y0};
        act1 = {bus1.y3, bus1.y2, bus1.y1, bus1.y0};
        total_cnt++;
        if (act8 === e.exp8) pass_cnt++;
        else $display("FAIL %s/w8: {y3,y2,y1,y0} actual %h expected %h", name, act8, e.exp8);
        total_cnt++;
        if (act1 === e.exp1) pass_cnt++;
        else $display("FAIL %s/w1: {y3,y2,y1,y0} actual %b expected %b", name, act1, e.exp1);
    endtask

    // Drive one set of inputs, then compare one clock later.
    task automatic apply(input string name, input logic en, input logic [1:0] sel,
                         input logic [7:0] d8, input logic d1,
                         input logic [31:0] e8, input logic [3:0] e1);
        drive(en, sel, d8, d1);
        push_exp(e8, e1);
        @(posedge clk);
        #1;
        check_pop(name);
    endtask

    // Called 1 time unit after a rising edge: asserts reset mid-cycle, releases it mid-cycle later.
    task automatic pulse_reset(input string name);
        #3;
        rst_n = 1'b0;
        #1;
        push_exp(32'h0, 4'h0);
        check_pop({name, "_async"});
        @(posedge clk);
        #1;
        push_exp(32'h0, 4'h0);
        check_pop({name, "_held"});
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] acc8;
        logic [3:0]  acc1;
        logic [31:0] e8;
        logic [3:0]  e1;

        tbl[0] = '{1'b1, 2'b01, 8'hA5, 1'b1, 32'h0000_A500, 4'b0010};
        tbl[2] = '{1'b0, 2'b00, 8'hFF, 1'b0, 32'h3C00_0000, 4'b1000};
        tbl[6] = '{1'b0, 2'b01, 8'h12, 1'b0, 32'h007E_0000, 4'b0100};
`ifdef DEMUX_HOLD_UNSEL_EN
        tbl[1] = '{1'b1, 2'b11, 8'h3C, 1'b1, 32'h3C00_A500, 4'b1010};
        tbl[2].exp8 = 32'h3C00_A500;
        tbl[2].exp1 = 4'b1010;
        tbl[3] = '{1'b1, 2'b10, 8'h00, 1'b0, 32'h3C00_A500, 4'b1010};
        tbl[4] = '{1'b1, 2'b00, 8'h81, 1'b1, 32'h3C00_A581, 4'b1011};
        tbl[5] = '{1'b1, 2'b10, 8'h7E, 1'b1, 32'h3C7E_A581, 4'b1111};
        tbl[6].exp8 = 32'h3C7E_A581;
        tbl[6].exp1 = 4'b1111;
        tbl[7] = '{1'b1, 2'b11, 8'hFF, 1'b0, 32'hFF7E_A581, 4'b0111};
`else
        tbl[1] = '{1'b1, 2'b11, 8'h3C, 1'b1, 32'h3C00_0000, 4'b1000};
        tbl[3] = '{1'b1, 2'b10, 8'h00, 1'b0, 32'h0000_0000, 4'b0000};
        tbl[4] = '{1'b1, 2'b00, 8'h81, 1'b1, 32'h0000_0081, 4'b0001};
        tbl[5] = '{1'b1, 2'b10, 8'h7E, 1'b1, 32'h007E_0000, 4'b0100};
        tbl[7] = '{1'b1, 2'b11, 8'hFF, 1'b0, 32'hFF00_0000, 4'b0000};
`endif

        rst_n = 1'b0;
        drive(1'b1, 2'b11, 8'hFF, 1'b1);
        #2;
        push_exp(32'h0, 4'h0);
        check_pop("reset_initial");
        @(posedge clk);
        #1;
        push_exp(32'h0, 4'h0);
        check_pop("reset_through_edge");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            apply($sformatf("table_%0d", i), tbl[i].en, tbl[i].sel, tbl[i].d8, tbl[i].d1,
                  tbl[i].exp8, tbl[i].exp1);
        end

        // Outputs are nonzero here, so the reset pulse must visibly clear them.
        pulse_reset("reset_nonzero");

        acc8 = 32'h0;
        acc1 = 4'h0;
        for (int i = 0; i < 4; i++) begin
            acc8 = acc8 | (32'h5A << (8 * i));
            acc1 = acc1 | 4'(1 << i);
`ifdef DEMUX_HOLD_UNSEL_EN
            e8 = acc8;
            e1 = acc1;
`else
            e8 = 32'h5A << (8 * i);
            e1 = 4'(1 << i);
`endif
            apply($sformatf("sweep_sel%0d", i), 1'b1, 2'(i), 8'h5A, 1'b1, e8, e1);
        end

        pulse_reset("reset_pre_zero");
        for (int i = 0; i < 4; i++) begin
            apply($sformatf("zero_sel%0d", i), 1'b1, 2'(i), 8'h00, 1'b0, 32'h0, 4'h0);
        end

        apply("hold_load", 1'b1, 2'b10, 8'hC3, 1'b1, 32'h00C3_0000, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            apply($sformatf("hold_en0_%0d", i), 1'b0, 2'b00, 8'h00, 1'b0, 32'h00C3_0000, 4'b0100);
        end

        pulse_reset("reset_pre_midop");
        apply("midop_load", 1'b1, 2'b00, 8'h01, 1'b1, 32'h0000_0001, 4'b0001);
        pulse_reset("reset_midop");
        apply("midop_reload", 1'b1, 2'b00, 8'h01, 1'b1, 32'h0000_0001, 4'b0001);
        apply("midop_switch", 1'b1, 2'b01, 8'h96, 1'b0,
`ifdef DEMUX_HOLD_UNSEL_EN
              32'h0000_9601, 4'b0001);
`else
              32'h0000_9600, 4'b0000);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
